// File: rtl/sdam_pkg.sv
// sdam_pkg: shared constants and state encoding for the SDAM write-frame scheduler.
package sdam_pkg;
  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 16;
  localparam int GAP_DEF = 2;
  localparam int CNT_W = 5;
  localparam logic CMD_WRITE = 1'b1;
  localparam logic START_BIT = 1'b0;
  typedef enum logic [2:0] {IDLE, START, CMD, ADDR, DATA, STOP} state_e;
endpackage

// File: rtl/sdam_frame_sched_if.sv
// sdam_frame_sched_if: two-requester write bus plus serial SDA drive of the frame scheduler.
interface sdam_frame_sched_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
);
  logic              req0, req1, gnt0, gnt1, done0, done1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [DATA_W-1:0] data0, data1;
  logic              sda_o, sda_oe, busy;
  modport master (
    output req0, addr0, data0, req1, addr1, data1,
    input  gnt0, gnt1, done0, done1, sda_o, sda_oe, busy
  );
  modport slave (
    input  req0, addr0, data0, req1, addr1, data1,
    output gnt0, gnt1, done0, done1, sda_o, sda_oe, busy
  );
endinterface

// File: rtl/sdam_rr_arb.sv
// sdam_rr_arb: 2-way round-robin arbiter; the pointer flips away from each winner.
module sdam_rr_arb (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       arb_en,
  output logic [1:0] gnt_onehot
);
  logic rr_q;
  always_comb gnt_onehot = !arb_en ? 2'b00 : (&req) ? (rr_q ? 2'b10 : 2'b01) : req;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rr_q <= 1'b0;
    else if (|gnt_onehot) rr_q <= gnt_onehot[0];
endmodule

// File: rtl/sdam_frame_sched.sv
// sdam_frame_sched: arbitrates two write requesters and serializes one START/CMD/ADDR/DATA/STOP
// frame per grant onto SDA, LSB first.
module sdam_frame_sched
  import sdam_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int GAP = GAP_DEF
) (
  input logic scl,
  input logic reset_n,
  sdam_frame_sched_if.slave bus
);
  localparam int SH_W = ADDR_W + DATA_W;
  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [SH_W-1:0]   sh_q, sh_d;
  logic              owner_q, owner_d, sda_q, sda_d, oe_q, oe_d;
  logic              gnt0_q, gnt1_q, done0_q, done1_q, done_d;
  logic [1:0]        gnt_oh;
  logic              last, arb_en;
  assign last = cnt_q == '0;
  assign arb_en = state_q == IDLE || (state_q == STOP && last);
  sdam_rr_arb u_arb (
    .clk(scl),
    .rst_n(reset_n),
    .req({bus.req1, bus.req0}),
    .arb_en(arb_en),
    .gnt_onehot(gnt_oh)
  );
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    sh_d = sh_q;
    owner_d = owner_q;
    case (state_q)
      IDLE, STOP: begin
        if (arb_en) state_d = |gnt_oh ? START : IDLE;
        else cnt_d = cnt_q - 1'b1;
      end
      START: state_d = CMD;
      CMD: begin
        state_d = ADDR;
        cnt_d = CNT_W'(ADDR_W - 1);
      end
      ADDR: begin
        sh_d = sh_q >> 1;
        state_d = last ? DATA : ADDR;
        cnt_d = last ? CNT_W'(DATA_W - 1) : cnt_q - 1'b1;
      end
      DATA: begin
        sh_d = sh_q >> 1;
        state_d = last ? STOP : DATA;
        cnt_d = last ? CNT_W'(GAP - 1) : cnt_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
    if (|gnt_oh) begin
      sh_d = gnt_oh[1] ? {bus.data1, bus.addr1} : {bus.data0, bus.addr0};
      owner_d = gnt_oh[1];
    end
    // Output registers carry the value of the state being entered, so SDA lines up with state_q.
    sda_d = state_d == START ? START_BIT : state_d == CMD ? CMD_WRITE :
            (state_d == ADDR || state_d == DATA) ? sh_d[0] : 1'b1;
    oe_d = state_d != IDLE;
    done_d = state_q == DATA && last;
  end
  always_ff @(posedge scl or negedge reset_n)
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      sh_q <= '0;
      owner_q <= 1'b0;
      sda_q <= 1'b1;
      oe_q <= 1'b0;
      gnt0_q <= 1'b0;
      gnt1_q <= 1'b0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      sh_q <= sh_d;
      owner_q <= owner_d;
      sda_q <= sda_d;
      oe_q <= oe_d;
      gnt0_q <= gnt_oh[0];
      gnt1_q <= gnt_oh[1];
      done0_q <= done_d && !owner_q;
      done1_q <= done_d && owner_q;
    end
  assign bus.gnt0 = gnt0_q;
  assign bus.gnt1 = gnt1_q;
  assign bus.done0 = done0_q;
  assign bus.done1 = done1_q;
  assign bus.sda_o = sda_q;
  assign bus.sda_oe = oe_q;
  assign bus.busy = state_q != IDLE;
endmodule
